// File: rtl/regfile_dump.sv
// Register file dump engine: walks indices 0..LAST_REG and streams each register as a
// valid/ready beat. It reads one register per beat and never has more than one beat in flight.
module regfile_dump #(
  parameter int unsigned N        = 64,
  parameter int unsigned LAST_REG = 31
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  output logic [4:0]   ra,
  input  logic [N-1:0] rd,
  output logic         dump_valid,
  input  logic         dump_ready,
  output logic [4:0]   dump_addr,
  output logic [N-1:0] dump_data,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

  localparam logic [4:0] LastIdx = 5'(LAST_REG);

  state_e       state_q, state_d;
  logic [4:0]   idx_q, idx_d;
  logic [4:0]   addr_q, addr_d;
  logic [N-1:0] data_q, data_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          idx_d   = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        addr_d  = idx_q;
        data_d  = rd;
        state_d = StSend;
      end
      StSend: begin
        // Beat is held until accepted; the index only advances on a transfer.
        if (dump_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = StRead;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy       = (state_q == StRead) || (state_q == StSend);
    ra         = busy ? idx_q : 5'd0;
    dump_valid = (state_q == StSend);
    done       = (state_q == StDone);
    dump_addr  = addr_q;
    dump_data  = data_q;
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: a behavioural register file answers ra combinationally,
// and each scenario task checks beat order, timing, backpressure and reset behaviour.
module tb_regfile_dump;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [4:0]  ra;
  logic [63:0] rd;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_addr;
  logic [63:0] dump_data;
  logic        busy;
  logic        done;

  // Register file model with one write port; x31 always reads zero.
  logic [63:0] rf [32];
  logic        we3;
  logic [4:0]  wa3;
  logic [63:0] wd3;

  always @(posedge clk) if (we3) rf[wa3] <= wd3;
  assign rd = (ra == 5'd31) ? 64'd0 : rf[ra];

  regfile_dump #(.N(64), .LAST_REG(31)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .ra         (ra),
    .rd         (rd),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Results of the most recent run_dump.
  logic [4:0]  beat_addr [64];
  logic [63:0] beat_data [64];
  int          beat_edge [64];
  int          nbeats;
  int          ndone;
  int          done_edge;
  int          drop_err;
  int          ra_err;

  task automatic write_reg(input logic [4:0] a, input logic [63:0] d);
    we3 = 1'b1; wa3 = a; wd3 = d;
    @(posedge clk); #1;
    we3 = 1'b0;
  endtask

  // Pulses start so that it is sampled at edge 0, then observes max_cyc further edges.
  // poke_beat >= 0 re-pulses start while that beat is valid.
  task automatic run_dump(input int poke_beat, input int max_cyc);
    logic prev_valid, prev_xfer, xfer, poked;
    nbeats = 0; ndone = 0; done_edge = -1; drop_err = 0; ra_err = 0;
    prev_valid = 1'b0; prev_xfer = 1'b0; poked = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= max_cyc; e++) begin
      if (done) begin
        ndone++;
        if (done_edge < 0) done_edge = e - 1;
      end
      if (prev_valid && !prev_xfer && !dump_valid) drop_err++;
      if (dump_valid && ra !== dump_addr) ra_err++;
      if (!busy && ra !== 5'd0) ra_err++;
      if (dump_valid && poke_beat >= 0 && int'(dump_addr) == poke_beat && !poked) begin
        start = 1'b1;
        poked = 1'b1;
      end
      xfer = dump_valid && dump_ready;
      if (xfer && nbeats < 64) begin
        beat_addr[nbeats] = dump_addr;
        beat_data[nbeats] = dump_data;
        beat_edge[nbeats] = e;
        nbeats++;
      end
      prev_valid = dump_valid;
      prev_xfer  = xfer;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({dump_valid, busy, done, ra, dump_addr} !== 13'd0 || dump_data !== 64'd0)
      $display("FAIL reset_immediate: got valid=%b busy=%b done=%b ra=%0d addr=%0d data=%0h, want all 0",
               dump_valid, busy, done, ra, dump_addr, dump_data);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({dump_valid, busy, done, ra, dump_addr} !== 13'd0 || dump_data !== 64'd0)
        $display("FAIL reset_hold[%0d]: got valid=%b busy=%b done=%b ra=%0d, want all 0",
                 c, dump_valid, busy, done, ra);
      else n_pass++;
    end
  endtask

  task automatic test_full_dump;
    logic [63:0] exp;
    run_dump(-1, 75);
    n_checks++;
    if (nbeats !== 32) $display("FAIL full_count: got %0d beats, want 32", nbeats);
    else n_pass++;
    for (int k = 0; k < 32 && k < nbeats; k++) begin
      exp = (k == 31) ? 64'd0 : 64'(k);
      n_checks++;
      if (beat_addr[k] !== 5'(k) || beat_data[k] !== exp || beat_edge[k] !== 2 + 2 * k)
        $display("FAIL full_beat[%0d]: got addr=%0d data=%0h edge=%0d, want addr=%0d data=%0h edge=%0d",
                 k, beat_addr[k], beat_data[k], beat_edge[k], k, exp, 2 + 2 * k);
      else n_pass++;
    end
    n_checks++;
    if (ndone !== 1 || done_edge !== 64)
      $display("FAIL full_done: got %0d pulses after edge %0d, want 1 after edge 64", ndone, done_edge);
    else n_pass++;
    n_checks++;
    if (drop_err !== 0 || ra_err !== 0)
      $display("FAIL full_protocol: got drops=%0d ra_errs=%0d, want 0/0", drop_err, ra_err);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL full_busy_after: got %b, want 0", busy);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    bit found = 0;
    bit seen_done = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (dump_valid && dump_addr == 5'd5) found = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    n_checks++;
    if (!found) $display("FAIL bp_reach_beat5: got no beat 5, want beat 5 valid");
    else n_pass++;
    dump_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (dump_valid !== 1'b1 || dump_addr !== 5'd5 || dump_data !== 64'd5 || ra !== 5'd5)
        $display("FAIL bp_hold[%0d]: got valid=%b addr=%0d data=%0h ra=%0d, want 1/5/5/5",
                 c, dump_valid, dump_addr, dump_data, ra);
      else n_pass++;
    end
    dump_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (dump_valid !== 1'b0 || busy !== 1'b1 || ra !== 5'd6)
      $display("FAIL bp_transfer: got valid=%b busy=%b ra=%0d, want 0/1/6", dump_valid, busy, ra);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (dump_valid !== 1'b1 || dump_addr !== 5'd6 || dump_data !== 64'd6)
      $display("FAIL bp_beat6: got valid=%b addr=%0d data=%0h, want 1/6/6", dump_valid, dump_addr, dump_data);
    else n_pass++;
    for (int c = 0; c < 80 && !seen_done; c++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1;
    end
    n_checks++;
    if (!seen_done) $display("FAIL bp_done: got no done pulse, want one");
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_write_then_dump;
    logic [63:0] exp;
    int bad = 0;
    write_reg(5'd2, 64'd27);
    run_dump(-1, 75);
    n_checks++;
    if (nbeats !== 32 || beat_data[2] !== 64'd27)
      $display("FAIL wr_beat2: got %0d beats, beat2 data=%0d, want 32 beats, data 27", nbeats, beat_data[2]);
    else n_pass++;
    for (int k = 0; k < 32 && k < nbeats; k++) begin
      exp = (k == 31) ? 64'd0 : (k == 2) ? 64'd27 : 64'(k);
      if (beat_data[k] !== exp || beat_addr[k] !== 5'(k)) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL wr_others: got %0d wrong beats, want 0", bad);
    else n_pass++;
    write_reg(5'd2, 64'd2);
  endtask

  task automatic test_start_while_busy;
    run_dump(7, 75);
    n_checks++;
    if (nbeats !== 32) $display("FAIL swb_count: got %0d beats, want 32", nbeats);
    else n_pass++;
    n_checks++;
    if (ndone !== 1 || done_edge !== 64)
      $display("FAIL swb_done: got %0d pulses after edge %0d, want 1 after edge 64", ndone, done_edge);
    else n_pass++;
    n_checks++;
    if (beat_addr[8] !== 5'd8 || beat_edge[8] !== 18)
      $display("FAIL swb_beat8: got addr=%0d edge=%0d, want 8/18", beat_addr[8], beat_edge[8]);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL swb_idle_after: got busy=%b, want 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_dump;
    bit found = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (dump_valid && dump_addr == 5'd10) found = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    n_checks++;
    if (!found) $display("FAIL rmd_reach_beat10: got no beat 10, want beat 10 valid");
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (dump_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dump_addr !== 5'd0 || ra !== 5'd0)
      $display("FAIL rmd_immediate: got valid=%b busy=%b done=%b addr=%0d ra=%0d, want all 0",
               dump_valid, busy, done, dump_addr, ra);
    else n_pass++;
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL rmd_no_done: got done=%b busy=%b, want 0/0", done, busy);
    else n_pass++;
    run_dump(-1, 75);
    n_checks++;
    if (nbeats !== 32 || beat_addr[0] !== 5'd0 || beat_data[0] !== 64'd0 || beat_edge[0] !== 2)
      $display("FAIL rmd_restart: got beats=%0d first addr=%0d data=%0h edge=%0d, want 32/0/0/2",
               nbeats, beat_addr[0], beat_data[0], beat_edge[0]);
    else n_pass++;
    n_checks++;
    if (ndone !== 1) $display("FAIL rmd_done: got %0d pulses, want 1", ndone);
    else n_pass++;
  endtask

  initial begin
    reset_n    = 1'b1;
    start      = 1'b0;
    dump_ready = 1'b1;
    we3        = 1'b0;
    wa3        = 5'd0;
    wd3        = 64'd0;
    test_reset();
    for (int i = 0; i < 32; i++) write_reg(5'(i), 64'(i));
    @(posedge clk); #1;
    test_full_dump();
    test_backpressure();
    test_write_then_dump();
    test_start_while_busy();
    test_reset_mid_dump();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
